// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline hazard, forwarding and run/freeze controller
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic [4:0]  addr_rs_id,
    input  logic [4:0]  addr_rt_id,
    input  logic        rs_used_id,
    input  logic        rt_used_id,
    input  logic [4:0]  regw_addr_exe,
    input  logic        wb_wen_exe,
    input  logic [4:0]  regw_addr_mem,
    input  logic        wb_wen_mem,
    input  logic        mem_ren_mem,
    input  logic [4:0]  regw_addr_wb,
    input  logic        wb_wen_wb,
    input  logic        is_branch_mem,
    output logic        if_rst,
    output logic        id_rst,
    output logic        exe_rst,
    output logic        mem_rst,
    output logic        wb_rst,
    output logic        if_en,
    output logic        id_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic [1:0]  exe_fwd_a_ctrl,
    output logic [1:0]  exe_fwd_b_ctrl,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  ctrl_state
);

    localparam logic [1:0] ST_INIT   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FREEZE = 2'b10;

    localparam logic [1:0] FWD_MEM_ALU = 2'b00;
    localparam logic [1:0] FWD_MEM_RD  = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [1:0] FWD_REGFILE = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic stall_evt;
    logic flush_evt;

    // Register 0 is hard-wired, so a write to it never produces a dependency.
    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst, input logic wen);
        return used && (src != 5'd0) && (src == dst) && wen;
    endfunction

    // MEM is the youngest producer with a forwarding path, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input logic [4:0] dst_mem, input logic wen_mem,
                                           input logic ren_mem, input logic [4:0] dst_wb,
                                           input logic wen_wb);
        if (src_match(used, src, dst_mem, wen_mem))
            return ren_mem ? FWD_MEM_RD : FWD_MEM_ALU;
        else if (src_match(used, src, dst_wb, wen_wb))
            return FWD_WB;
        else
            return FWD_REGFILE;
    endfunction

    // Operand selects and the EXE load-use/ALU hazard; no forwarding path from EXE exists.
    always_comb begin
        exe_fwd_a_ctrl = fwd_sel(rs_used_id, addr_rs_id, regw_addr_mem, wb_wen_mem,
                                 mem_ren_mem, regw_addr_wb, wb_wen_wb);
        exe_fwd_b_ctrl = fwd_sel(rt_used_id, addr_rt_id, regw_addr_mem, wb_wen_mem,
                                 mem_ren_mem, regw_addr_wb, wb_wen_wb);
        hazard = src_match(rs_used_id, addr_rs_id, regw_addr_exe, wb_wen_exe) ||
                 src_match(rt_used_id, addr_rt_id, regw_addr_exe, wb_wen_exe);
        flush_evt = (state_q == ST_RUN) && is_branch_mem;
        stall_evt = (state_q == ST_RUN) && hazard && !is_branch_mem;
    end

    // Mode sequencing and saturating event counters.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == 2'd1)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!run_en)
                    state_d = ST_FREEZE;
            end
            ST_FREEZE: begin
                if (run_en)
                    state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 2'd0;
            end
        endcase
        if (stall_evt && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_evt && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // State and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Per-stage clear/enable decode; a branch flush overrides a stall.
    always_comb begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
        {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
        if (rst) begin
            {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
        end else begin
            case (state_q)
                ST_RUN: begin
                    {if_en, id_en, exe_en, mem_en, wb_en} = 5'b11111;
                    if (is_branch_mem) begin
                        id_rst  = 1'b1;
                        exe_rst = 1'b1;
                    end else if (hazard) begin
                        if_en   = 1'b0;
                        id_en   = 1'b0;
                        exe_rst = 1'b1;
                    end
                end
                ST_FREEZE: begin
                end
                default: begin
                    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
                end
            endcase
        end
    end

    assign ctrl_state = rst ? ST_INIT : state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic [4:0]  addr_rs_id, addr_rt_id;
    logic        rs_used_id, rt_used_id;
    logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic        wb_wen_exe, wb_wen_mem, mem_ren_mem, wb_wen_wb;
    logic        is_branch_mem;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0]  exe_fwd_a_ctrl, exe_fwd_b_ctrl;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  ctrl_state;

    int total = 0;
    int bad   = 0;

    wire [4:0] rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
    wire [4:0] en_v  = {if_en, id_en, exe_en, mem_en, wb_en};

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .is_branch_mem(is_branch_mem),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        addr_rs_id = 5'd0; addr_rt_id = 5'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b0;
        regw_addr_mem = 5'd0; wb_wen_mem = 1'b0; mem_ren_mem = 1'b0;
        regw_addr_wb = 5'd0; wb_wen_wb = 1'b0;
        is_branch_mem = 1'b0;
    endtask

    task automatic reset_to_run();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_en = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++; if (rst_v !== 5'b11111) begin bad++; $display("FAIL reset_rst got=%b exp=11111", rst_v); end
        total++; if (en_v !== 5'b00000) begin bad++; $display("FAIL reset_en got=%b exp=00000", en_v); end
        total++; if ({ctrl_state, exe_fwd_a_ctrl, exe_fwd_b_ctrl} !== 6'b00_11_11) begin bad++; $display("FAIL reset_state_fwd got=%b exp=001111", {ctrl_state, exe_fwd_a_ctrl, exe_fwd_b_ctrl}); end
        total++; if ({stall_cnt, flush_cnt} !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, flush_cnt}); end
        rst = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                total++; if (rst_v !== 5'b11111 || ctrl_state !== 2'b00) begin bad++; $display("FAIL init_edge1 rst=%b state=%b exp=11111/00", rst_v, ctrl_state); end
            end else begin
                total++; if (ctrl_state !== 2'b01 || en_v !== 5'b11111 || rst_v !== 5'b00000) begin bad++; $display("FAIL init_to_run state=%b en=%b rst=%b exp=01/11111/00000", ctrl_state, en_v, rst_v); end
            end
        end
        @(negedge clk);
        total++; if (ctrl_state !== 2'b01) begin bad++; $display("FAIL init_cycle1_state got=%b exp=01", ctrl_state); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        addr_rs_id = 5'd5; rs_used_id = 1'b1;
        regw_addr_mem = 5'd5; wb_wen_mem = 1'b1; mem_ren_mem = 1'b0;
        #1;
        total++; if (exe_fwd_a_ctrl !== 2'b00) begin bad++; $display("FAIL fwd_mem_alu got=%b exp=00", exe_fwd_a_ctrl); end
        mem_ren_mem = 1'b1; #1;
        total++; if (exe_fwd_a_ctrl !== 2'b01) begin bad++; $display("FAIL fwd_mem_rd got=%b exp=01", exe_fwd_a_ctrl); end
        regw_addr_mem = 5'd6; regw_addr_wb = 5'd5; wb_wen_wb = 1'b1; #1;
        total++; if (exe_fwd_a_ctrl !== 2'b10) begin bad++; $display("FAIL fwd_wb got=%b exp=10", exe_fwd_a_ctrl); end
        @(negedge clk);
        addr_rt_id = 5'd9; rt_used_id = 1'b1; regw_addr_mem = 5'd9; mem_ren_mem = 1'b0;
        regw_addr_wb = 5'd9; #1;
        total++; if ({exe_fwd_a_ctrl, exe_fwd_b_ctrl} !== 4'b11_00) begin bad++; $display("FAIL fwd_b_mem_over_wb got=%b exp=1100", {exe_fwd_a_ctrl, exe_fwd_b_ctrl}); end
        wb_wen_mem = 1'b0; #1;
        total++; if (exe_fwd_b_ctrl !== 2'b10) begin bad++; $display("FAIL fwd_b_mem_wen0 got=%b exp=10", exe_fwd_b_ctrl); end
        @(negedge clk);
        addr_rs_id = 5'd0; addr_rt_id = 5'd0; regw_addr_mem = 5'd0; wb_wen_mem = 1'b1;
        regw_addr_wb = 5'd0; regw_addr_exe = 5'd0; wb_wen_exe = 1'b1; #1;
        total++; if ({exe_fwd_a_ctrl, exe_fwd_b_ctrl, en_v} !== 9'b11_11_11111) begin bad++; $display("FAIL fwd_reg0 got=%b exp=111111111", {exe_fwd_a_ctrl, exe_fwd_b_ctrl, en_v}); end
        idle_inputs();
    endtask

    task automatic test_stall();
        @(negedge clk);
        addr_rt_id = 5'd7; rt_used_id = 1'b1; regw_addr_exe = 5'd7; wb_wen_exe = 1'b1; #1;
        total++; if (en_v !== 5'b00111 || rst_v !== 5'b00100) begin bad++; $display("FAIL stall_decode en=%b rst=%b exp=00111/00100", en_v, rst_v); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt_before got=%0d exp=0", stall_cnt); end
        @(posedge clk); #1;
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt_inc got=%0d exp=1", stall_cnt); end
        @(negedge clk);
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b0; #1;
        total++; if (en_v !== 5'b11111 || rst_v !== 5'b00000) begin bad++; $display("FAIL stall_release en=%b rst=%b exp=11111/00000", en_v, rst_v); end
        @(posedge clk); #1;
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt_hold got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        regw_addr_exe = 5'd7; wb_wen_exe = 1'b1; is_branch_mem = 1'b1; #1;
        total++; if (rst_v !== 5'b01100 || en_v !== 5'b11111) begin bad++; $display("FAIL flush_decode rst=%b en=%b exp=01100/11111", rst_v, en_v); end
        @(posedge clk); #1;
        total++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin bad++; $display("FAIL flush_cnt flush=%0d stall=%0d exp=1/1", flush_cnt, stall_cnt); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_freeze();
        @(negedge clk);
        run_en = 1'b0;
        @(posedge clk); #1;
        addr_rt_id = 5'd7; rt_used_id = 1'b1; regw_addr_exe = 5'd7; wb_wen_exe = 1'b1;
        addr_rs_id = 5'd3; rs_used_id = 1'b1; regw_addr_mem = 5'd3; wb_wen_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (ctrl_state !== 2'b10 || en_v !== 5'b00000 || rst_v !== 5'b00000) begin bad++; $display("FAIL freeze_%0d state=%b en=%b rst=%b exp=10/00000/00000", i, ctrl_state, en_v, rst_v); end
        end
        total++; if ({stall_cnt, flush_cnt} !== {16'd1, 16'd1} || exe_fwd_a_ctrl !== 2'b00) begin bad++; $display("FAIL freeze_hold stall=%0d flush=%0d fwd_a=%b exp=1/1/00", stall_cnt, flush_cnt, exe_fwd_a_ctrl); end
        @(negedge clk);
        run_en = 1'b1; #1;
        total++; if (ctrl_state !== 2'b10) begin bad++; $display("FAIL freeze_exit_early got=%b exp=10", ctrl_state); end
        @(posedge clk); #1;
        total++; if (ctrl_state !== 2'b01 || en_v !== 5'b00111 || rst_v !== 5'b00100) begin bad++; $display("FAIL freeze_pending_stall state=%b en=%b rst=%b exp=01/00111/00100", ctrl_state, en_v, rst_v); end
        @(posedge clk); #1;
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL freeze_stall_cnt got=%0d exp=2", stall_cnt); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_saturate_and_async_rst();
        reset_to_run();
        total++; if ({stall_cnt, flush_cnt} !== 32'd0 || ctrl_state !== 2'b01) begin bad++; $display("FAIL resat_start cnt=%h state=%b exp=0/01", {stall_cnt, flush_cnt}, ctrl_state); end
        @(negedge clk);
        addr_rs_id = 5'd12; rs_used_id = 1'b1; regw_addr_exe = 5'd12; wb_wen_exe = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=FFFE", stall_cnt); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=FFFF", stall_cnt); end
        #2;
        idle_inputs();
        rst = 1'b1; #1;
        total++; if (rst_v !== 5'b11111 || en_v !== 5'b00000 || ctrl_state !== 2'b00) begin bad++; $display("FAIL async_rst_ctrl rst=%b en=%b state=%b exp=11111/00000/00", rst_v, en_v, ctrl_state); end
        total++; if ({stall_cnt, flush_cnt} !== 32'd0 || {exe_fwd_a_ctrl, exe_fwd_b_ctrl} !== 4'b1111) begin bad++; $display("FAIL async_rst_cnt cnt=%h fwd=%b exp=0/1111", {stall_cnt, flush_cnt}, {exe_fwd_a_ctrl, exe_fwd_b_ctrl}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL async_rst_reinit got=%b exp=00", ctrl_state); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_stall();
        test_flush();
        test_freeze();
        test_saturate_and_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
